// File: rtl/pito_loader_pkg.sv
// pito_loader_pkg
//    Shared definitions for the pito program loader: loader state encoding,
//    frame field sizes and the bit offsets of the header fields.
//    No ports (package).
package pito_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      DATA,
      CSUM,
      RUN,
      ERR
   } loader_state_e;

   // Bytes per header and per data/checksum word.
   localparam int HDR_BYTES  = 4;
   localparam int WORD_BYTES = 4;

   // Header word layout (little-endian assembled word).
   localparam int HDR_COUNT_LSB = 0;    // word_count N
   localparam int HDR_ADDR_LSB  = 16;   // start_addr A
   localparam int HDR_FIELD_W   = 16;   // width of each field in the frame

endpackage

// File: rtl/pito_prog_loader_packer.sv
// byte_to_word_packer
//    Assembles little-endian 32-bit words from a byte stream. Byte 0 of each
//    group lands in bits [7:0]. word_valid is combinational and pulses in the
//    same cycle the 4th byte is accepted, so the consumer can act on the
//    completed word at that clock edge without a bubble.
//
//    Ports:
//       clk        in   system clock
//       rst        in   synchronous active-high reset
//       clr        in   synchronous clear of the byte counter and shift register
//       byte_en    in   a byte is accepted this cycle
//       byte_in    in   [7:0]  accepted byte
//       word_valid out  completed word available this cycle
//       word       out  [31:0] completed word (valid with word_valid)
module byte_to_word_packer
   import pito_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        byte_en,
   input  logic [7:0]  byte_in,
   output logic        word_valid,
   output logic [31:0] word
);

   localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);

   logic [1:0]  byte_cnt_reg;
   logic [23:0] shift_reg;

   // Bytes enter at the top and shift down, so after three bytes the
   // register holds {b2, b1, b0}; the 4th byte completes the word directly.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         byte_cnt_reg <= '0;
         shift_reg    <= '0;
      end else if (byte_en) begin
         byte_cnt_reg <= byte_cnt_reg + 2'd1;
         shift_reg    <= {byte_in, shift_reg[23:8]};
      end
   end

   assign word_valid = byte_en && (byte_cnt_reg == LAST_BYTE);
   assign word       = {byte_in, shift_reg};

endmodule

// File: rtl/pito_prog_loader.sv
// pito_prog_loader
//    Boot-time loader for the pito core. Receives a framed byte stream
//    (header {start_addr, word_count}, N data words, additive checksum),
//    writes the data words into instruction memory and releases the core
//    from reset only when the checksum matches.
//
//    Ports:
//       clk           in   system clock
//       rst           in   synchronous active-high reset
//       s_byte        in   [7:0]  stream byte
//       s_valid       in   stream byte valid
//       s_ready       out  loader accepts a byte this cycle (HDR/DATA/CSUM)
//       reload        in   restart a load from RUN or ERR
//       imem_we       out  instruction-memory write strobe (one cycle/word)
//       imem_addr     out  [ADDR_W-1:0] word address of the write
//       imem_wdata    out  [31:0] word data of the write
//       core_rst      out  active-high reset to the pito core
//       done          out  load verified, core running
//       err           out  load failed, core held in reset
//       words_loaded  out  [LEN_W-1:0] words written in the current load
module pito_prog_loader
   import pito_loader_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int LEN_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        s_byte,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic              reload,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_rst,
   output logic              done,
   output logic              err,
   output logic [LEN_W-1:0]  words_loaded
);

   // Memory depth expressed at LEN_W+1 bits so A+N can be compared without
   // overflow.
   localparam logic [LEN_W:0] MEM_DEPTH = {{LEN_W{1'b0}}, 1'b1} << ADDR_W;

   loader_state_e state_reg, state_next;

   logic [LEN_W-1:0]  count_reg;
   logic [ADDR_W-1:0] start_reg;
   logic [31:0]       sum_reg;
   logic [LEN_W-1:0]  words_loaded_reg;
   logic              imem_we_reg;
   logic [ADDR_W-1:0] imem_addr_reg;
   logic [31:0]       imem_wdata_reg;

   logic        accept;
   logic        reload_take;
   logic        word_valid;
   logic [31:0] word;

   logic [LEN_W-1:0] hdr_count;
   logic [LEN_W-1:0] hdr_addr;
   logic [LEN_W:0]   hdr_end;
   logic             hdr_bad;
   logic             last_word;

   assign s_ready     = (state_reg == HDR) || (state_reg == DATA) || (state_reg == CSUM);
   assign accept      = s_valid && s_ready;
   assign reload_take = reload && ((state_reg == RUN) || (state_reg == ERR));

   byte_to_word_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .clr        (reload_take),
      .byte_en    (accept),
      .byte_in    (s_byte),
      .word_valid (word_valid),
      .word       (word)
   );

   // Header decode straight off the packer so the state can change on the
   // edge that accepts the 4th header byte.
   assign hdr_count = word[HDR_COUNT_LSB +: LEN_W];
   assign hdr_addr  = word[HDR_ADDR_LSB  +: LEN_W];
   assign hdr_end   = {1'b0, hdr_addr} + {1'b0, hdr_count};
   assign hdr_bad   = hdr_end > MEM_DEPTH;
   assign last_word = (words_loaded_reg + LEN_W'(1)) == count_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: state_next = HDR;
         HDR: begin
            if (word_valid) begin
               if (hdr_bad) begin
                  state_next = ERR;
               end else if (hdr_count == '0) begin
                  state_next = CSUM;
               end else begin
                  state_next = DATA;
               end
            end
         end
         DATA: begin
            if (word_valid && last_word) begin
               state_next = CSUM;
            end
         end
         CSUM: begin
            if (word_valid) begin
               state_next = (word == sum_reg) ? RUN : ERR;
            end
         end
         RUN, ERR: begin
            if (reload) begin
               state_next = HDR;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg        <= '0;
         start_reg        <= '0;
         sum_reg          <= '0;
         words_loaded_reg <= '0;
         imem_we_reg      <= 1'b0;
         imem_addr_reg    <= '0;
         imem_wdata_reg   <= '0;
      end else begin
         imem_we_reg <= 1'b0;
         if (reload_take) begin
            sum_reg          <= '0;
            words_loaded_reg <= '0;
         end
         if (state_reg == HDR && word_valid) begin
            count_reg        <= hdr_count;
            start_reg        <= hdr_addr[ADDR_W-1:0];
            sum_reg          <= '0;
            words_loaded_reg <= '0;
         end
         if (state_reg == DATA && word_valid) begin
            // A + i cannot wrap: the header check bounded A + N.
            imem_we_reg      <= 1'b1;
            imem_addr_reg    <= start_reg + words_loaded_reg[ADDR_W-1:0];
            imem_wdata_reg   <= word;
            sum_reg          <= sum_reg + word;
            words_loaded_reg <= words_loaded_reg + LEN_W'(1);
         end
      end
   end

   assign imem_we      = imem_we_reg;
   assign imem_addr    = imem_addr_reg;
   assign imem_wdata   = imem_wdata_reg;
   assign words_loaded = words_loaded_reg;

   // Core control follows the state directly: only a verified load runs.
   assign core_rst = (state_reg != RUN);
   assign done     = (state_reg == RUN);
   assign err      = (state_reg == ERR);

endmodule

// File: tb/tb_pito_prog_loader.sv
// tb_pito_prog_loader
//    Randomized, scoreboard-checked bench for pito_prog_loader. The stimulus
//    side computes each frame's expected memory writes and final status from
//    the frame rules; a monitor pops expected writes whenever imem_we fires.
module tb_pito_prog_loader;

   localparam int ADDR_W = 12;
   localparam int LEN_W  = 16;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst;
   logic [7:0]        s_byte;
   logic              s_valid;
   logic              s_ready;
   logic              reload;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              core_rst;
   logic              done;
   logic              err;
   logic [LEN_W-1:0]  words_loaded;

   pito_prog_loader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .s_byte       (s_byte),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .reload       (reload),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .core_rst     (core_rst),
      .done         (done),
      .err          (err),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [ADDR_W-1:0] exp_addr_q[$];
   logic [31:0]       exp_data_q[$];
   logic [31:0]       fw [0:15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every write strobe must match the head of the expected queue.
   always @(negedge clk) begin : monitor
      logic [ADDR_W-1:0] ea;
      logic [31:0]       ed;
      if (!rst) begin
         if (imem_we) begin
            if (exp_addr_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_write: got addr 0x%03h data 0x%08h, expected no write",
                        imem_addr, imem_wdata);
            end else begin
               ea = exp_addr_q.pop_front();
               ed = exp_data_q.pop_front();
               chk("wr_addr", 32'(imem_addr), 32'(ea));
               chk("wr_data", imem_wdata, ed);
               $display("write addr=0x%03h data=0x%08h", imem_addr, imem_wdata);
            end
         end
         if (done || err) begin
            chk("s_ready_outside_load", 32'(s_ready), 32'd0);
         end
      end
   end

   task automatic check_reset_values(input string tag);
      chk({tag, "_s_ready"},      32'(s_ready),      32'd0);
      chk({tag, "_imem_we"},      32'(imem_we),      32'd0);
      chk({tag, "_imem_addr"},    32'(imem_addr),    32'd0);
      chk({tag, "_imem_wdata"},   imem_wdata,        32'd0);
      chk({tag, "_core_rst"},     32'(core_rst),     32'd1);
      chk({tag, "_done"},         32'(done),         32'd0);
      chk({tag, "_err"},          32'(err),          32'd0);
      chk({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst     = 1'b1;
      s_valid = 1'b0;
      reload  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_reset_values(tag);
      rst = 1'b0;
      #1;
      chk({tag, "_idle_ready"}, 32'(s_ready), 32'd0);
      @(negedge clk);
      chk({tag, "_hdr_ready"}, 32'(s_ready), 32'd1);
      $display("reset %s", tag);
   endtask

   task automatic do_reload();
      @(negedge clk);
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
      chk("reload_done",         32'(done),         32'd0);
      chk("reload_err",          32'(err),          32'd0);
      chk("reload_core_rst",     32'(core_rst),     32'd1);
      chk("reload_words_loaded", 32'(words_loaded), 32'd0);
      chk("reload_s_ready",      32'(s_ready),      32'd1);
      $display("reload");
   endtask

   // Present one byte until accepted; thr inserts random idle cycles.
   task automatic send_byte(input logic [7:0] b, input bit thr, output bit ok);
      int tries;
      tries = 0;
      ok    = 1'b0;
      while (!ok && tries < 200) begin
         @(negedge clk);
         tries++;
         if (thr && $urandom_range(1, 0) == 0) begin
            s_valid = 1'b0;
            s_byte  = 8'($urandom);
         end else begin
            s_valid = 1'b1;
            s_byte  = b;
            if (s_ready) ok = 1'b1;
         end
      end
      if (ok) begin
         @(posedge clk);
      end else begin
         n_cmp++;
         n_bad++;
         $display("FAIL byte_timeout: got no acceptance in 200 cycles, expected s_ready");
      end
   endtask

   task automatic push_word_bytes(input logic [31:0] w, inout logic [7:0] q[$]);
      for (int k = 0; k < 4; k++) q.push_back(w[8*k +: 8]);
   endtask

   // Stream one frame built from fw[0:n-1] and check the outcome the frame
   // rules predict: header range test, N writes, checksum verdict.
   task automatic run_frame(input int n, input int a, input logic [31:0] csum,
                            input bit thr, input string tag);
      bit          hdr_ok;
      bit          pass;
      bit          ok;
      logic [31:0] s;
      logic [31:0] hdr;
      logic [7:0]  bq[$];
      hdr_ok = (n + a) <= DEPTH;
      s = 32'd0;
      for (int i = 0; i < n; i++) s = s + fw[i];
      pass = hdr_ok && (s == csum);
      hdr = {16'(a), 16'(n)};
      push_word_bytes(hdr, bq);
      if (hdr_ok) begin
         for (int i = 0; i < n; i++) begin
            exp_addr_q.push_back(ADDR_W'((a + i) % DEPTH));
            exp_data_q.push_back(fw[i]);
            push_word_bytes(fw[i], bq);
         end
         push_word_bytes(csum, bq);
      end
      foreach (bq[k]) begin
         send_byte(bq[k], thr, ok);
         if (!ok) break;
      end
      @(negedge clk);
      s_valid = 1'b0;
      chk({tag, "_done"},         32'(done),         32'(pass));
      chk({tag, "_err"},          32'(err),          32'(!pass));
      chk({tag, "_core_rst"},     32'(core_rst),     32'(!pass));
      chk({tag, "_words_loaded"}, 32'(words_loaded), hdr_ok ? 32'(n) : 32'd0);
      chk({tag, "_s_ready"},      32'(s_ready),      32'd0);
      repeat (6) @(negedge clk);
      chk({tag, "_writes_drained"}, 32'(exp_addr_q.size()), 32'd0);
      chk({tag, "_done_hold"},      32'(done),              32'(pass));
      $display("frame %s n=%0d a=0x%03h csum=0x%08h done=%0d err=%0d",
               tag, n, a, csum, done, err);
   endtask

   initial begin
      int          n;
      int          a;
      logic [31:0] cs;
      logic [31:0] hdr;
      logic [7:0]  bq[$];
      bit          ok;

      rst     = 1'b1;
      s_valid = 1'b0;
      s_byte  = 8'h00;
      reload  = 1'b0;
      do_reset("por");

      fw[0] = 32'h0000_0013;
      fw[1] = 32'hDEAD_BEEF;
      run_frame(2, 'h010, 32'hDEADBF02, 1'b0, "basic");
      do_reload();
      run_frame(2, 'h010, 32'hDEADBF02, 1'b1, "throttled");
      do_reload();
      run_frame(2, 'h010, 32'hDEADBF03, 1'b0, "bad_csum");
      do_reload();
      run_frame(2, 'h010, 32'hDEADBF02, 1'b0, "after_err");
      do_reload();
      run_frame(0, 0, 32'h0, 1'b0, "empty");
      do_reload();
      run_frame(2, 'hFFF, 32'hDEADBF02, 1'b0, "range_err");
      do_reload();
      run_frame(2, 'hFFE, 32'hDEADBF02, 1'b0, "top_fit");

      // Abort after 5 data bytes of a 3-word load; only word 0 gets written.
      do_reset("pre_abort");
      fw[2] = 32'h1234_5678;
      hdr = {16'h0020, 16'd3};
      push_word_bytes(hdr, bq);
      for (int i = 0; i < 3; i++) push_word_bytes(fw[i], bq);
      exp_addr_q.push_back(ADDR_W'('h020));
      exp_data_q.push_back(fw[0]);
      for (int k = 0; k < 9; k++) begin
         send_byte(bq[k], 1'b0, ok);
         if (!ok) break;
      end
      do_reset("abort");
      chk("abort_writes_drained", 32'(exp_addr_q.size()), 32'd0);
      run_frame(3, 'h020, fw[0] + fw[1] + fw[2], 1'b0, "after_abort");

      // Random frames: random size, address, data, verdict and pacing.
      for (int f = 0; f < 8; f++) begin
         do_reload();
         n = $urandom_range(8, 1);
         a = ($urandom_range(5, 0) == 0) ? $urandom_range(DEPTH - 1, DEPTH - n + 1)
                                         : $urandom_range(DEPTH - n, 0);
         cs = 32'd0;
         for (int i = 0; i < n; i++) begin
            fw[i] = $urandom;
            cs    = cs + fw[i];
         end
         if ($urandom_range(3, 0) == 0) cs = cs ^ (32'd1 << $urandom_range(31, 0));
         run_frame(n, a, cs, 1'($urandom_range(1, 0)), "random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
